// File: rtl/spi_rx_bram_in.sv
// ---------------------------------------------------------------------------
// spi_rx_bram_in
//
// SPI mode-0 slave receiver feeding the write port of spi_xil_bram_out.
// The SPI pins are oversampled in the clka0 domain. Each complete MOSI byte
// (MSB first) is written into a 2^ADDR_W entry ring buffer. This block owns
// the ring write pointer. A byte is dropped, and a sticky overflow flag is
// raised, when the ring is full. At the end of every chip-select frame it
// pulses frame_done and reports how many bytes that frame wrote.
//
// Ports:
//   clka0       in   write-side clock, also the SPI oversampling clock
//   rstn        in   asynchronous active-low reset
//   spi_sclk    in   SPI clock (mode 0), asynchronous to clka0
//   spi_cs_n    in   SPI chip select, active low, frames a transfer
//   spi_mosi    in   SPI serial data, MSB first
//   rd_ptr      in   buffer read pointer (binary, clka0 domain)
//   clr_ovf     in   single-cycle clear of overflow
//   wen0        out  one-cycle BRAM write strobe
//   wdata0      out  byte to write, valid while wen0 = 1
//   waddr0      out  write address (the ring write pointer)
//   frame_done  out  one-cycle pulse at end of frame
//   frame_len   out  bytes written in the last frame
//   overflow    out  sticky: a byte was dropped because the ring was full
// ---------------------------------------------------------------------------
module spi_rx_bram_in #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clka0,
    input  logic              rstn,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    input  logic [ADDR_W-1:0] rd_ptr,
    input  logic              clr_ovf,
    output logic              wen0,
    output logic [DATA_W-1:0] wdata0,
    output logic [ADDR_W-1:0] waddr0,
    output logic              frame_done,
    output logic [ADDR_W:0]   frame_len,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [ADDR_W:0] FRAME_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE,
        DONE
    } StateT;

    StateT r_state;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic                   r_sclkD;
    logic                   r_csD;

    logic [CNT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_shift;
    logic [ADDR_W:0]   r_frameCnt;
    logic [ADDR_W-1:0] r_wrPtr;
    logic              r_csPend;
    logic              r_wen0;
    logic [DATA_W-1:0] r_wdata0;
    logic              r_frameDone;
    logic [ADDR_W:0]   r_frameLen;
    logic              r_overflow;

    logic              w_sclk;
    logic              w_cs;
    logic              w_mosi;
    logic              w_sclkRise;
    logic              w_csFall;
    logic              w_csRise;
    logic [ADDR_W-1:0] w_wrPtrNext;
    logic              w_full;

    // All three SPI pins go through chains of identical depth so that MOSI
    // stays aligned with the SCLK edge it belongs to. The extra sclk/cs flops
    // feed the edge detectors. Reset puts the chains in the bus-idle state
    // (sclk low, cs high), so leaving reset never looks like an edge.
    always_ff @(posedge clka0 or negedge rstn) begin
        if (!rstn) begin
            r_sclkSync <= '0;
            r_csSync   <= '1;
            r_mosiSync <= '0;
            r_sclkD    <= 1'b0;
            r_csD      <= 1'b1;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
            r_sclkD    <= w_sclk;
            r_csD      <= w_cs;
        end
    end

    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_cs       = r_csSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_sclkRise = w_sclk & ~r_sclkD;
    assign w_csFall   = ~w_cs & r_csD;
    assign w_csRise   = w_cs & ~r_csD;

    // One slot stays empty so that full and empty can be told apart.
    assign w_wrPtrNext = r_wrPtr + ADDR_W'(1);
    assign w_full      = (w_wrPtrNext == rd_ptr);

    // Receive FSM with registered write-port and frame outputs.
    // The pointer advances on the edge that ends the wen0 cycle. waddr0 is
    // therefore still the written address while wen0 is high.
    // A cs rise seen in the cycle where the byte completes is held in
    // r_csPend, so the byte is still written before the frame closes.
    // clr_ovf is applied before the case statement so that a drop in the
    // same cycle overrides it.
    always_ff @(posedge clka0 or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_frameCnt  <= '0;
            r_wrPtr     <= '0;
            r_csPend    <= 1'b0;
            r_wen0      <= 1'b0;
            r_wdata0    <= '0;
            r_frameDone <= 1'b0;
            r_frameLen  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wen0      <= 1'b0;
            r_frameDone <= 1'b0;

            if (r_wen0) begin
                r_wrPtr <= w_wrPtrNext;
            end

            if (clr_ovf) begin
                r_overflow <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_csFall) begin
                        r_state    <= SHIFT;
                        r_bitCnt   <= '0;
                        r_shift    <= '0;
                        r_frameCnt <= '0;
                    end
                end

                SHIFT: begin
                    if (r_bitCnt == CNT_W'(DATA_W)) begin
                        r_state  <= WRITE;
                        r_csPend <= w_csRise;
                    end else if (w_csRise) begin
                        r_state <= DONE;
                    end else if (w_sclkRise) begin
                        r_shift  <= {r_shift[DATA_W-2:0], w_mosi};
                        r_bitCnt <= r_bitCnt + CNT_W'(1);
                    end
                end

                WRITE: begin
                    if (!w_full) begin
                        r_wen0   <= 1'b1;
                        r_wdata0 <= r_shift;
                        if (r_frameCnt != FRAME_MAX) begin
                            r_frameCnt <= r_frameCnt + (ADDR_W + 1)'(1);
                        end
                    end else begin
                        r_overflow <= 1'b1;
                    end
                    r_bitCnt <= '0;
                    r_csPend <= 1'b0;
                    if (w_csRise || r_csPend) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= SHIFT;
                    end
                end

                DONE: begin
                    r_frameDone <= 1'b1;
                    r_frameLen  <= r_frameCnt;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wen0       = r_wen0;
    assign wdata0     = r_wdata0;
    assign waddr0     = r_wrPtr;
    assign frame_done = r_frameDone;
    assign frame_len  = r_frameLen;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spi_rx_bram_in.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_bram_in
//
// Directed bench for spi_rx_bram_in. An SPI master task drives mode-0 frames
// from the falling edge of clka0. A monitor logs every write and frame_done,
// and the test sequence compares the logs with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_spi_rx_bram_in;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clka0 = 1'b0;
    logic              rstn;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic [ADDR_W-1:0] rd_ptr;
    logic              clr_ovf;
    logic              wen0;
    logic [DATA_W-1:0] wdata0;
    logic [ADDR_W-1:0] waddr0;
    logic              frame_done;
    logic [ADDR_W:0]   frame_len;
    logic              overflow;

    int errCount   = 0;
    int checkCount = 0;
    int cycCnt     = 0;
    int lastRiseCyc = 0;

    int wrAddrQ[$];
    int wrDataQ[$];
    int wrLatQ[$];
    int fdLenQ[$];
    logic [7:0] txQ[$];

    spi_rx_bram_in #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clka0(clka0),
        .rstn(rstn),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .rd_ptr(rd_ptr),
        .clr_ovf(clr_ovf),
        .wen0(wen0),
        .wdata0(wdata0),
        .waddr0(waddr0),
        .frame_done(frame_done),
        .frame_len(frame_len),
        .overflow(overflow)
    );

    // 100 MHz write-side clock.
    always #5 clka0 = ~clka0;

    // Free-running edge counter, used to measure write latency.
    always @(posedge clka0) cycCnt <= cycCnt + 1;

    // Log writes and frame ends away from the active edge. The latency is
    // measured in edges after the one that first samples the last sclk high.
    always @(negedge clka0) begin
        if (wen0) begin
            wrAddrQ.push_back(int'(waddr0));
            wrDataQ.push_back(int'(wdata0));
            wrLatQ.push_back(cycCnt - lastRiseCyc - 1);
        end
        if (frame_done) begin
            fdLenQ.push_back(int'(frame_len));
        end
    end

    // Hard bound on total simulation time.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        wrAddrQ.delete();
        wrDataQ.delete();
        wrLatQ.delete();
        fdLenQ.delete();
    endtask

    // Shift nBits of b (MSB first) with sclk high and low for 'half' cycles
    // each. If collide is set, clr_ovf is raised on the edge where the
    // completed byte's WRITE cycle ends (4 edges after the final rise is
    // sampled).
    task automatic sendBits(input logic [7:0] b, input int nBits, input int half,
                            input bit collide);
        for (int i = 7; i > 7 - nBits; i--) begin
            spi_mosi = b[i];
            repeat (half) @(negedge clka0);
            spi_sclk = 1'b1;
            if (i == 0) lastRiseCyc = cycCnt;
            for (int k = 1; k <= half; k++) begin
                @(negedge clka0);
                if (collide && i == 0) clr_ovf = (k == 4);
            end
            spi_sclk = 1'b0;
            for (int k = 1; k <= half; k++) begin
                @(negedge clka0);
                if (collide) clr_ovf = 1'b0;
            end
        end
    endtask

    // One chip-select frame: every byte in txQ, then an optional partial
    // byte. After cs_n rises, wait long enough for frame_done.
    task automatic applyStimulus(input int half, input int extraBits,
                                 input logic [7:0] extraByte, input bit collideLast);
        spi_cs_n = 1'b0;
        repeat (half) @(negedge clka0);
        foreach (txQ[j]) begin
            sendBits(txQ[j], 8, half, collideLast && (j == txQ.size() - 1));
        end
        if (extraBits > 0) sendBits(extraByte, extraBits, half, 1'b0);
        repeat (half) @(negedge clka0);
        spi_cs_n = 1'b1;
        repeat (20) @(negedge clka0);
    endtask

    // Expect one write per txQ byte at consecutive ring addresses from base.
    task automatic checkWrites(input string tag, input int baseAddr);
        checkOutput({tag, ".count"}, wrAddrQ.size(), txQ.size());
        for (int j = 0; j < txQ.size(); j++) begin
            checkOutput($sformatf("%s.addr%0d", tag, j),
                        (j < wrAddrQ.size()) ? wrAddrQ[j] : -1, (baseAddr + j) % DEPTH);
            checkOutput($sformatf("%s.data%0d", tag, j),
                        (j < wrDataQ.size()) ? wrDataQ[j] : -1, int'(txQ[j]));
        end
    endtask

    task automatic checkFrame(input string tag, input int expLen);
        checkOutput({tag, ".fdCount"}, fdLenQ.size(), 1);
        checkOutput({tag, ".frameLen"}, (fdLenQ.size() > 0) ? fdLenQ[0] : -1, expLen);
    endtask

    initial begin
        bit seqOk;

        rstn     = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        rd_ptr   = '0;
        clr_ovf  = 1'b0;

        // Outputs while held in reset.
        repeat (3) @(negedge clka0);
        checkOutput("reset.wen0", wen0, 0);
        checkOutput("reset.wdata0", wdata0, 0);
        checkOutput("reset.waddr0", waddr0, 0);
        checkOutput("reset.frame_done", frame_done, 0);
        checkOutput("reset.frame_len", frame_len, 0);
        checkOutput("reset.overflow", overflow, 0);
        rstn = 1'b1;
        repeat (5) @(negedge clka0);

        // Three-byte frame at sclk = clka0/8.
        clearLogs();
        txQ = '{8'hA5, 8'h3C, 8'hFF};
        applyStimulus(4, 0, 8'h00, 1'b0);
        checkWrites("single", 0);
        checkFrame("single", 3);
        for (int j = 0; j < 3; j++)
            checkOutput($sformatf("single.latency%0d", j), (j < wrLatQ.size()) ? wrLatQ[j] : -1, SYNC + 2);
        checkOutput("single.overflow", overflow, 0);

        // One full byte and five stray bits: only 0x81 is written.
        clearLogs();
        txQ = '{8'h81};
        applyStimulus(4, 5, 8'hB8, 1'b0);
        checkWrites("partial", 3);
        checkFrame("partial", 1);

        // Latency at sclk = clka0/10.
        clearLogs();
        txQ = '{8'h5A};
        applyStimulus(5, 0, 8'h00, 1'b0);
        checkWrites("ratio10", 4);
        checkOutput("ratio10.latency", (wrLatQ.size() > 0) ? wrLatQ[0] : -1, SYNC + 2);

        // Reset after four bits of a byte.
        clearLogs();
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clka0);
        sendBits(8'hF0, 4, 4, 1'b0);
        rstn     = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        @(negedge clka0);
        checkOutput("midReset.wen0", wen0, 0);
        checkOutput("midReset.wdata0", wdata0, 0);
        checkOutput("midReset.waddr0", waddr0, 0);
        checkOutput("midReset.frame_len", frame_len, 0);
        checkOutput("midReset.overflow", overflow, 0);
        repeat (2) @(negedge clka0);
        rstn = 1'b1;
        repeat (10) @(negedge clka0);
        checkOutput("midReset.noWrite", wrAddrQ.size(), 0);
        txQ = '{8'h77};
        applyStimulus(4, 0, 8'h00, 1'b0);
        checkWrites("postReset", 0);

        // Fill the ring at sclk = clka0/4. 2047 bytes fit, the 2048th drops.
        rstn = 1'b0;
        repeat (2) @(negedge clka0);
        rstn = 1'b1;
        repeat (5) @(negedge clka0);
        clearLogs();
        txQ.delete();
        for (int i = 0; i < DEPTH; i++) txQ.push_back(8'(i % 256));
        applyStimulus(2, 0, 8'h00, 1'b0);
        checkOutput("wrap.count", wrAddrQ.size(), DEPTH - 1);
        checkOutput("wrap.lastAddr", (wrAddrQ.size() > 0) ? wrAddrQ[wrAddrQ.size()-1] : -1, DEPTH - 2);
        checkOutput("wrap.lastData", (wrDataQ.size() > 0) ? wrDataQ[wrDataQ.size()-1] : -1, (DEPTH - 2) % 256);
        seqOk = (wrAddrQ.size() == DEPTH - 1);
        for (int j = 0; j < wrAddrQ.size() && j < DEPTH - 1; j++)
            if (wrAddrQ[j] != j || wrDataQ[j] != j % 256) seqOk = 1'b0;
        checkOutput("wrap.sequence", seqOk, 1);
        checkOutput("wrap.overflow", overflow, 1);
        checkOutput("wrap.latency", (wrLatQ.size() > 0) ? wrLatQ[0] : -1, SYNC + 2);
        checkFrame("wrap", DEPTH - 1);

        // Reader advances. Clear overflow. The write pointer wraps past 2047.
        rd_ptr  = 11'd5;
        clr_ovf = 1'b1;
        @(negedge clka0);
        clr_ovf = 1'b0;
        @(negedge clka0);
        checkOutput("clear.overflow", overflow, 0);
        clearLogs();
        txQ = '{8'h11, 8'h22, 8'h33};
        applyStimulus(4, 0, 8'h00, 1'b0);
        checkWrites("wrapAround", DEPTH - 1);
        checkOutput("wrapAround.overflow", overflow, 0);
        checkFrame("wrapAround", 3);

        // Two bytes fill to wr=4 (rd=5). The third drops while clr_ovf is high.
        clearLogs();
        txQ = '{8'h44, 8'h55, 8'h66};
        applyStimulus(4, 0, 8'h00, 1'b1);
        checkOutput("collide.count", wrAddrQ.size(), 2);
        checkOutput("collide.addr0", (wrAddrQ.size() > 0) ? wrAddrQ[0] : -1, 2);
        checkOutput("collide.addr1", (wrAddrQ.size() > 1) ? wrAddrQ[1] : -1, 3);
        checkOutput("collide.overflow", overflow, 1);
        checkFrame("collide", 2);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
